// File: rtl/trivium_prng_stream.sv
// rtl/trivium_prng_stream.sv - Trivium keystream generator, NBITS per step, with warm-up and reseed accounting
module trivium_prng_stream #(
    parameter int NBITS           = 64,
    parameter int WARMUP_STEPS    = (1152 + NBITS - 1) / NBITS,
    parameter int RESEED_INTERVAL = 0,
    parameter int STALL_AT_LIMIT  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reseed,
    input  logic [79:0]      key,
    input  logic [79:0]      iv,
    output logic             rand_valid,
    input  logic             rand_ready,
    output logic [NBITS-1:0] rand_data,
    output logic             seeded,
    output logic             busy,
    output logic             reseed_req,
    output logic [31:0]      word_count
);

    localparam int WCW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [287:0]     s_q;
    logic [287:0]     s_step;
    logic [287:0]     s_seed;
    logic [NBITS-1:0] z_step;
    logic [WCW-1:0]   warm_cnt_q;
    logic             handshake;
    logic             stalled;
    logic             load;

    // Bit i of the state vector holds s(i+1); result is {z, next_state}.
    function automatic logic [288:0] trivium_round(input logic [287:0] s);
        logic t1, t2, t3, n1, n2, n3;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        n1 = t1 ^ (s[90] & s[91]) ^ s[170];
        n2 = t2 ^ (s[174] & s[175]) ^ s[263];
        n3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {t1 ^ t2 ^ t3, s[286:177], n2, s[175:93], n1, s[91:0], n3};
    endfunction

    // Earliest round of the step lands in the MSB of the word.
    always_comb begin
        s_step = s_q;
        z_step = '0;
        for (int k = 0; k < NBITS; k++) begin
            {z_step[NBITS-1-k], s_step} = trivium_round(s_step);
        end
    end

    always_comb begin
        s_seed = '0;
        for (int i = 0; i < 80; i++) begin
            s_seed[i]      = key[79-i];
            s_seed[93 + i] = iv[79-i];
        end
        s_seed[287:285] = 3'b111;
    end

    assign handshake = rand_valid && rand_ready;
    assign stalled   = (STALL_AT_LIMIT != 0) && reseed_req;
    assign load      = (state_q == ST_RUN) && (!rand_valid || rand_ready) && !stalled;
    assign seeded    = (state_q == ST_RUN);
    assign busy      = (state_q == ST_WARMUP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_WARMUP: if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
        if (reseed) state_d = ST_WARMUP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q        <= '0;
            warm_cnt_q <= '0;
            rand_valid <= 1'b0;
            rand_data  <= '0;
            word_count <= '0;
            reseed_req <= 1'b0;
        end else if (reseed) begin
            // A pending word is dropped and a coincident handshake is not counted.
            s_q        <= s_seed;
            warm_cnt_q <= '0;
            rand_valid <= 1'b0;
            word_count <= '0;
            reseed_req <= 1'b0;
        end else begin
            if (state_q == ST_WARMUP) begin
                s_q        <= s_step;
                warm_cnt_q <= warm_cnt_q + WCW'(1);
            end
            if (load) begin
                s_q        <= s_step;
                rand_data  <= z_step;
                rand_valid <= 1'b1;
            end else if (handshake) begin
                rand_valid <= 1'b0;
            end
            if (handshake) begin
                if (word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
                if ((RESEED_INTERVAL != 0) && (word_count + 32'd1 == 32'(RESEED_INTERVAL)))
                    reseed_req <= 1'b1;
            end
        end
    end

endmodule

// File: doc/trivium_prng_stream.md
# trivium_prng_stream

Parametrised successor of the team's 64-bit Trivium generator. It produces NBITS keystream bits per clock and runs the full 1152-round Trivium warm-up before releasing any output. Output words are delivered over a valid/ready handshake, and a reseed-request flag is raised after a programmable number of delivered words. It sits between the seed source (key/IV registers) and the masking datapath's randomness consumers.

## Interface
- NBITS, 64: keystream bits per step. Legal range 1..64.
- WARMUP_STEPS, ceil(1152/NBITS): discarded steps after each reseed. Must be ≥ 1.
- RESEED_INTERVAL, 0: delivered words before `reseed_req` asserts. 0 disables the flag.
- STALL_AT_LIMIT, 0: 1 means no new words are issued once the interval is reached, until the next reseed.

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- reseed  in  1  single-cycle request to load key/iv and restart warm-up
- key  in  80  Trivium key, sampled only on the cycle `reseed`=1
- iv  in  80  Trivium IV, sampled only on the cycle `reseed`=1
- rand_valid  out  1  `rand_data` holds an unconsumed word
- rand_ready  in  1  consumer accepts the word this cycle
- rand_data  out  NBITS  keystream word
- seeded  out  1  the core is in RUN
- busy  out  1  the core is in WARMUP
- reseed_req  out  1  delivered-word count ≥ RESEED_INTERVAL (only when RESEED_INTERVAL ≠ 0)
- word_count  out  32  words delivered since the last reseed, saturating at 2^32−1

## Operation
- **State layout:** 288-bit state s1..s288.
  - On load: s1..s80 = key[79:0] with s1 = key[79]; s81..s93 = 0.
  - s94..s173 = iv[79:0] with s94 = iv[79]; s174..s285 = 0; s286..s288 = 1.
- **One round:**
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1' = t1^(s91&s92)^s171; t2' = t2^(s175&s176)^s264; t3' = t3^(s286&s287)^s69.
  - Shift: (s1..s93) ← (t3', s1..s92); (s94..s177) ← (t1', s94..s176); (s178..s288) ← (t2', s178..s287).
- **One step = NBITS unrolled rounds.** `rand_data[NBITS-1]` = the earliest z of the step, and `rand_data[0]` = the latest.
- **FSM states:**
  - IDLE: after reset, nothing seeded. `reseed` → WARMUP.
  - WARMUP: one step per cycle with z discarded. When the counter reaches WARMUP_STEPS−1 → RUN.
  - RUN: a step is taken and its word loaded into `rand_data` only when (!`rand_valid` || `rand_ready`) and not stalled. `rand_valid` ← 1 on load.
  - If not loading and `rand_ready` && `rand_valid`, then `rand_valid` ← 0.
- **Reseed from any state:**
  - Load state from key/iv and clear the warm-up counter.
  - Clear `word_count` and `reseed_req`; force `rand_valid` ← 0. A pending word is dropped, not delivered.
  - Go to WARMUP.
- **word_count:** increments on every handshake (`rand_valid` && `rand_ready`) and saturates at 2^32−1.
- **reseed_req:** set when the incremented count equals RESEED_INTERVAL; held until reseed.
- **Stall:** with STALL_AT_LIMIT=1 and `reseed_req`=1, no new word is loaded. The word already held stays valid until consumed.
- **State freeze:** the keystream state never advances in IDLE or RUN-stalled, so no keystream bits are skipped.

## Timing
- **Reset values:**
  - `rand_valid` 0, `rand_data` 0, `seeded` 0, `busy` 0, `reseed_req` 0, `word_count` 0.
  - FSM IDLE; state register all-zero.
- **Reseed latency:**
  - `reseed` sampled at edge E0 → state loaded, `busy` 1 after E0.
  - Warm-up steps at edges E1..E_W, where W = WARMUP_STEPS.
  - After E_W: `busy` 0, `seeded` 1.
  - First word loaded at edge E_{W+1} → `rand_valid` 1 after E_{W+1}. For NBITS=64 this is 19 cycles after `reseed`.
- **Throughput:** with `rand_ready` held 1, one new word per cycle and `rand_valid` stays 1.
- **Stability:** `rand_data` is stable while `rand_valid` && !`rand_ready`.
- **Simultaneous events:**
  - `reseed` with a handshake in the same cycle: the handshake does not count, and the word is treated as dropped.
  - `reseed` while already in WARMUP restarts warm-up from the new key/iv.
- **reset_n low mid-operation:** immediate return to reset values with no clock required. Outputs stay at reset values until the first clk edge after release.

## Test plan
- **Reset then idle:** reset_n low 3 cycles, no reseed for 50 cycles → `rand_valid`=0, `seeded`=0, `busy`=0 throughout.
- **Known answer:** NBITS=64, key=0, iv=0, reseed, `rand_ready`=1.
  - `rand_valid` rises exactly 19 cycles after `reseed`.
  - The first 8 words equal the Trivium reference model's keystream bits 0..511 in MSB-first order.
- **Width sweep and equivalence:** NBITS ∈ {1, 8, 17, 64}.
  - WARMUP_STEPS = 1152, 144, 68, 18 respectively.
  - The concatenated output stream matches a bit-serial model that performs the same number of discarded rounds (1152 for widths dividing 1152; 1156 for NBITS=17).
- **Back-pressure:** drop `rand_ready` randomly 50% of cycles.
  - `rand_data` is unchanged while stalled.
  - The delivered stream equals the no-back-pressure stream.
  - `word_count` equals the number of handshakes.
- **Reseed limit:** RESEED_INTERVAL=4, STALL_AT_LIMIT=1.
  - `reseed_req` rises with the 4th handshake; exactly 5 words are delivered.
  - A subsequent reseed clears `word_count` to 0 and `reseed_req` to 0.
- **Mid-operation events:**
  - Reseed with `rand_valid`=1 and `rand_ready`=0 → `rand_valid`=0 next cycle, `busy`=1.
  - reset_n pulse during WARMUP → all outputs return to reset values asynchronously.
